// File: rtl/alu_hn_unit.sv
// rtl/alu_hn_unit.sv - multi-cycle ALU with iterative shifter, registered flags and gated S-bus output
//
// Ports:
//   CLK, CLR        clock (rising edge) and asynchronous active-high reset
//   start           operation request, sampled only while idle
//   op              000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 PASS A, 110 SHL, 111 SHR
//   a_in, b_in      operands
//   cin             carry input for ADD
//   shamt           shift count for SHL/SHR
//   ALS             S-bus output enable for H_out
//   busy            high whenever the unit is not idle
//   done            one-cycle completion pulse
//   H_out           result_bus gated by ALS
//   result_bus      ungated result register
//   carry, overflow, zero, negative   status flags of the last completed operation

module alu_hn_unit #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 5
) (
    input  logic               CLK,
    input  logic               CLR,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    input  logic               cin,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               ALS,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   H_out,
    output logic [WIDTH-1:0]   result_bus,
    output logic               carry,
    output logic               overflow,
    output logic               zero,
    output logic               negative
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   sh_reg;
    logic               sh_right;
    logic [SHAMT_W-1:0] cnt;
    logic [WIDTH-1:0]   result_q;

    // Single-cycle datapath. Zero-count shifts fall into the default arm
    // and complete immediately as a pass of A with carry cleared.
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c;
    logic             alu_v;

    always_comb begin
        b_eff = (op == 3'b001) ? ~b_in : b_in;
        c_eff = (op == 3'b001) ? 1'b1 : cin;
        sum   = {1'b0, a_in} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_eff};
        alu_r = a_in;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (op)
            3'b000, 3'b001: begin
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                // Same-sign operands producing an opposite-sign sum
                alu_v = (a_in[WIDTH-1] == b_eff[WIDTH-1]) &&
                        (sum[WIDTH-1] != a_in[WIDTH-1]);
            end
            3'b010:  alu_r = a_in & b_in;
            3'b011:  alu_r = a_in | b_in;
            3'b100:  alu_r = a_in ^ b_in;
            default: alu_r = a_in;
        endcase
    end

    // One-bit shift step; the bit leaving the register becomes carry on the
    // final step, so counts beyond WIDTH naturally end with zeros and carry 0.
    logic [WIDTH-1:0] sh_next;
    logic             sh_out;

    always_comb begin
        sh_next = sh_right ? {1'b0, sh_reg[WIDTH-1:1]} : {sh_reg[WIDTH-2:0], 1'b0};
        sh_out  = sh_right ? sh_reg[0] : sh_reg[WIDTH-1];
    end

    logic start_shift;
    assign start_shift = op[2] && op[1] && (shamt != '0);

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state    <= ST_IDLE;
            sh_reg   <= '0;
            sh_right <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (start_shift) begin
                            sh_reg   <= a_in;
                            sh_right <= op[0];
                            cnt      <= shamt;
                            state    <= ST_SHIFT;
                        end else begin
                            result_q <= alu_r;
                            carry    <= alu_c;
                            overflow <= alu_v;
                            zero     <= (alu_r == '0);
                            negative <= alu_r[WIDTH-1];
                            done     <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    sh_reg <= sh_next;
                    cnt    <= cnt - SHAMT_W'(1);
                    if (cnt == SHAMT_W'(1)) begin
                        result_q <= sh_next;
                        carry    <= sh_out;
                        overflow <= 1'b0;
                        zero     <= (sh_next == '0);
                        negative <= sh_next[WIDTH-1];
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign result_bus = result_q;
    assign H_out      = ALS ? result_q : '0;

endmodule

// File: doc/alu_hn_unit.md
ALU_HN_UNIT -- requirements
Module: alu_hn_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16: datapath width in bits, minimum 2.
REQ-002 SHALL have parameter SHAMT_W, default 5: shift-count width; 2**SHAMT_W >= WIDTH.
REQ-003 SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port CLR, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: operation request; sampled only in IDLE.
REQ-006 SHALL have port op, input, 3 bits: operation select; encoding in REQ-020.
REQ-007 SHALL have port a_in, input, WIDTH bits: operand A.
REQ-008 SHALL have port b_in, input, WIDTH bits: operand B.
REQ-009 SHALL have port cin, input, 1 bit: carry input for ADD.
REQ-010 SHALL have port shamt, input, SHAMT_W bits: shift count for SHL/SHR.
REQ-011 SHALL have port ALS, input, 1 bit: S-bus output enable.
REQ-012 SHALL have port busy, output, 1 bit: high whenever state != IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have port H_out, output, WIDTH bits: result gated by ALS.
REQ-015 SHALL have port result_bus, output, WIDTH bits: ungated result register, used for PSW.
REQ-016 SHALL have ports carry, overflow, zero, negative, output, 1 bit each: registered status flags.

Function
REQ-017 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-018 In IDLE, start=1 at edge k SHALL latch op/a_in/b_in/cin/shamt; a_in/b_in/cin/shamt changes after edge k SHALL NOT affect the operation.
REQ-019 Non-shift ops and shifts with shamt=0 SHALL be computed at edge k and enter DONE, so done=1 in cycle k+1 (latency 1).
REQ-020 op encoding SHALL be: 000 ADD A+B+cin; 001 SUB A+~B+1; 010 AND; 011 OR; 100 XOR; 101 PASS A; 110 SHL logical; 111 SHR logical.
REQ-021 ADD/SUB: carry SHALL be the bit-WIDTH carry-out, with SUB carry=1 meaning no borrow; overflow SHALL be signed two's-complement overflow.
REQ-022 Logic ops and PASS SHALL clear carry and overflow.
REQ-023 SHL/SHR with shamt=N>0 SHALL load A at edge k, enter SHIFT, shift one bit per edge for N edges, then enter DONE, so done=1 in cycle k+N+1.
REQ-024 Each shift SHALL shift in 0; carry SHALL be the last bit shifted out; overflow SHALL be 0.
REQ-025 N >= WIDTH SHALL give result 0; carry SHALL be the last bit shifted out.
REQ-026 zero SHALL equal (result==0) and negative SHALL equal result MSB, both for the completed op.
REQ-027 Result and all flags SHALL update only on entry to DONE and hold until the next completion.
REQ-028 DONE SHALL last exactly one cycle and return to IDLE unconditionally; done=1 only in DONE.
REQ-029 start SHALL be ignored while busy=1, with no queuing; start during DONE is ignored.
REQ-030 H_out SHALL equal result_bus when ALS=1 and all-zero when ALS=0, combinationally, in any state.

Reset
REQ-031 CLR=1 SHALL immediately force state IDLE, the result register, all flags, busy, done and the shift counter to 0, regardless of CLK.
REQ-032 CLR asserted during SHIFT SHALL abort the operation: no done pulse and no result update.
REQ-033 On CLR deassertion, the first start SHALL be accepted on the next rising edge.

Verification
REQ-034 The bench SHALL check ADD a=0x7FFF b=0x0001 cin=0 -> done in cycle k+1; result 0x8000; overflow=1, carry=0, negative=1, zero=0.
REQ-035 The bench SHALL check SUB a=0x0005 b=0x0005 -> result 0x0000; zero=1, carry=1, overflow=0.
REQ-036 The bench SHALL check SHL a=0x8001 shamt=3 -> busy for cycles k+1..k+4; done in cycle k+4; result 0x0008; carry=0.
REQ-037 The bench SHALL check SHR a=0x0003 shamt=20 -> result 0x0000, carry=0, zero=1, done in cycle k+21.
REQ-038 The bench SHALL check that with result 0xA5A5 held, toggling ALS 1->0->1 drives H_out 0xA5A5 -> 0x0000 -> 0xA5A5 while result_bus stays 0xA5A5.
REQ-039 The bench SHALL check: start during SHIFT is ignored, then CLR mid-SHIFT gives busy=0, done=0, result 0x0000, and the next start completes normally.
